// File: rtl/movimiento_rx_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : movimiento_rx_decoder
// Purpose  : 8N1 UART receiver feeding a timed two-channel H-bridge motion decoder.
// Revision : 1.0
// ============================================================================
module movimiento_rx_decoder #(
  parameter int CLKS_PER_BIT = 434,
  parameter int UNIT_CLKS    = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] cmd_byte,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic [1:0] motor_l,
  output logic [1:0] motor_r,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int UW = (UNIT_CLKS > 1) ? $clog2(UNIT_CLKS) : 1;

  localparam logic [CW-1:0] c_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [UW-1:0] c_UNIT_LAST = UW'(UNIT_CLKS - 1);

  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_START = 3'd1,
    R_DATA  = 3'd2,
    R_STOP  = 3'd3,
    R_WAIT  = 3'd4
  } rx_state_t;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_RUN  = 1'b1
  } mo_state_t;

  logic            r_rx_meta;
  logic            r_rxs;
  rx_state_t       r_rx_state;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic [7:0]      r_cmd_byte;
  logic            r_cmd_valid;
  logic            r_frame_err;

  mo_state_t       r_mo_state;
  logic [UW-1:0]   r_unit_cnt;
  logic [5:0]      r_remaining;
  logic [1:0]      r_motor_l;
  logic [1:0]      r_motor_r;
  logic            r_busy;

  logic [1:0]      w_op;
  logic [1:0]      w_ml;
  logic [1:0]      w_mr;
  logic [5:0]      w_dur;

  // Synchronizer presets high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rxs     <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state  <= R_IDLE;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_cmd_byte  <= '0;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_rx_state)
        R_IDLE: begin
          if (!r_rxs) begin
            r_rx_state <= R_START;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
          end
        end
        R_START: begin
          if (r_clk_cnt == c_HALF_LAST) begin
            r_clk_cnt  <= '0;
            r_rx_state <= r_rxs ? R_IDLE : R_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (r_clk_cnt == c_BIT_LAST) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rxs, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) begin
              r_rx_state <= R_STOP;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (r_clk_cnt == c_BIT_LAST) begin
            r_clk_cnt <= '0;
            if (r_rxs) begin
              r_cmd_byte  <= r_shift;
              r_cmd_valid <= 1'b1;
              r_rx_state  <= R_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_rx_state  <= R_WAIT;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        R_WAIT: begin
          // A held-low line (break) must return high before a new start is accepted.
          if (r_rxs) begin
            r_rx_state <= R_IDLE;
          end
        end
        default: r_rx_state <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    w_op  = r_cmd_byte[7:6];
    w_ml  = 2'b00;
    w_mr  = 2'b00;
    w_dur = r_cmd_byte[5:0];
    case (w_op)
      2'b01: begin
        w_ml = 2'b10;
        w_mr = 2'b10;
      end
      2'b10: begin
        w_ml = 2'b01;
        w_mr = 2'b01;
      end
      2'b11: begin
        w_dur = {1'b0, r_cmd_byte[4:0]};
        if (r_cmd_byte[5]) begin
          w_ml = 2'b10;
          w_mr = 2'b01;
        end else begin
          w_ml = 2'b01;
          w_mr = 2'b10;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mo_state  <= M_IDLE;
      r_unit_cnt  <= '0;
      r_remaining <= '0;
      r_motor_l   <= 2'b00;
      r_motor_r   <= 2'b00;
      r_busy      <= 1'b0;
    end else if (r_cmd_valid) begin
      // Any accepted byte preempts whatever is running.
      r_unit_cnt <= '0;
      if (w_op == 2'b00) begin
        r_mo_state  <= M_IDLE;
        r_remaining <= '0;
        r_motor_l   <= 2'b00;
        r_motor_r   <= 2'b00;
        r_busy      <= 1'b0;
      end else begin
        r_mo_state  <= M_RUN;
        r_remaining <= w_dur;
        r_motor_l   <= w_ml;
        r_motor_r   <= w_mr;
        r_busy      <= 1'b1;
      end
    end else if (r_mo_state == M_RUN) begin
      if (r_unit_cnt == c_UNIT_LAST) begin
        r_unit_cnt <= '0;
        // Zero remaining means run until the next command.
        if (r_remaining == 6'd1) begin
          r_mo_state  <= M_IDLE;
          r_remaining <= '0;
          r_motor_l   <= 2'b00;
          r_motor_r   <= 2'b00;
          r_busy      <= 1'b0;
        end else if (r_remaining != 6'd0) begin
          r_remaining <= r_remaining - 1'b1;
        end
      end else begin
        r_unit_cnt <= r_unit_cnt + 1'b1;
      end
    end
  end

  assign cmd_byte  = r_cmd_byte;
  assign cmd_valid = r_cmd_valid;
  assign frame_err = r_frame_err;
  assign motor_l   = r_motor_l;
  assign motor_r   = r_motor_r;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_movimiento_rx_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_movimiento_rx_decoder
// Purpose  : Directed self-checking bench for movimiento_rx_decoder.
// Revision : 1.0
// ============================================================================
module tb_movimiento_rx_decoder;

  localparam int CPB  = 16;
  localparam int UNIT = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_i = 1'b1;
  logic [7:0] cmd_byte;
  logic       cmd_valid;
  logic       frame_err;
  logic [1:0] motor_l;
  logic [1:0] motor_r;
  logic       busy;

  movimiento_rx_decoder #(
    .CLKS_PER_BIT(CPB),
    .UNIT_CLKS   (UNIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_i     (rx_i),
    .cmd_byte (cmd_byte),
    .cmd_valid(cmd_valid),
    .frame_err(frame_err),
    .motor_l  (motor_l),
    .motor_r  (motor_r),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int         cyc = 0;
  int         valid_cnt = 0;
  int         err_cnt = 0;
  int         fall_cnt = 0;
  int         valid_cyc = 0;
  int         rise_cyc = 0;
  int         fall_cyc = 0;
  logic [7:0] last_byte = 8'h00;
  logic       prev_busy = 1'b0;

  // Event recorder: pulse counts and busy edge timestamps in negedge cycles.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (cmd_valid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
      last_byte = cmd_byte;
    end
    if (frame_err === 1'b1) err_cnt = err_cnt + 1;
    if (busy === 1'b1 && prev_busy !== 1'b1) rise_cyc = cyc;
    if (busy !== 1'b1 && prev_busy === 1'b1) begin
      fall_cnt = fall_cnt + 1;
      fall_cyc = cyc;
    end
    prev_busy = busy;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int extra_low);
    @(negedge clk) rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = stop_bit;
    repeat (CPB + extra_low) @(negedge clk);
    rx_i = 1'b1;
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
    end
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_byte !== 8'h00 || cmd_valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_rx: byte=%h valid=%b err=%b expected 00/0/0", cmd_byte, cmd_valid, frame_err);
    end
    checks++;
    if ({motor_l, motor_r, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_motion: got %b expected 00000", {motor_l, motor_r, busy});
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_fwd;
    int v0, f0;
    v0 = valid_cnt;
    send_byte(8'h43, 1'b1, 0);
    checks++;
    if (valid_cnt !== v0 + 1 || last_byte !== 8'h43) begin
      failures++;
      $display("FAIL fwd_rx: valids=%0d byte=%h expected %0d/43", valid_cnt - v0, last_byte, 1);
    end
    checks++;
    if ({motor_l, motor_r, busy} !== 5'b10101) begin
      failures++;
      $display("FAIL fwd_motors: got %b expected 10101", {motor_l, motor_r, busy});
    end
    checks++;
    if (rise_cyc !== valid_cyc + 1) begin
      failures++;
      $display("FAIL fwd_latency: got %0d expected 1", rise_cyc - valid_cyc);
    end
    f0 = fall_cnt;
    wait_idle(400);
    checks++;
    if (fall_cnt !== f0 + 1 || fall_cyc - rise_cyc !== 300) begin
      failures++;
      $display("FAIL fwd_duration: got %0d expected 300", fall_cyc - rise_cyc);
    end
    checks++;
    if ({motor_l, motor_r} !== 4'b0000) begin
      failures++;
      $display("FAIL fwd_off: got %b expected 0000", {motor_l, motor_r});
    end
  endtask

  task automatic test_turn;
    int f0;
    send_byte(8'hE5, 1'b1, 0);
    checks++;
    if ({motor_l, motor_r, busy} !== 5'b10011) begin
      failures++;
      $display("FAIL turn_right: got %b expected 10011", {motor_l, motor_r, busy});
    end
    wait_idle(600);
    checks++;
    if (busy !== 1'b0 || fall_cyc - rise_cyc !== 500) begin
      failures++;
      $display("FAIL turn_duration: got %0d expected 500", fall_cyc - rise_cyc);
    end
    send_byte(8'hC0, 1'b1, 0);
    checks++;
    if ({motor_l, motor_r, busy} !== 5'b01101) begin
      failures++;
      $display("FAIL turn_left: got %b expected 01101", {motor_l, motor_r, busy});
    end
    f0 = fall_cnt;
    repeat (10000) @(negedge clk);
    #1;
    checks++;
    if ({motor_l, motor_r, busy} !== 5'b01101 || fall_cnt !== f0) begin
      failures++;
      $display("FAIL continuous: got %b falls=%0d expected 01101 falls=0", {motor_l, motor_r, busy}, fall_cnt - f0);
    end
  endtask

  task automatic test_stop;
    send_byte(8'h8A, 1'b1, 0);
    checks++;
    if ({motor_l, motor_r, busy} !== 5'b01011) begin
      failures++;
      $display("FAIL back_start: got %b expected 01011", {motor_l, motor_r, busy});
    end
    repeat (200) @(negedge clk);
    send_byte(8'h00, 1'b1, 0);
    checks++;
    if (last_byte !== 8'h00 || {motor_l, motor_r, busy} !== 5'b0) begin
      failures++;
      $display("FAIL stop_cmd: byte=%h motion=%b expected 00/00000", last_byte, {motor_l, motor_r, busy});
    end
    checks++;
    if (fall_cyc !== valid_cyc + 1) begin
      failures++;
      $display("FAIL stop_latency: got %0d expected 1", fall_cyc - valid_cyc);
    end
  endtask

  task automatic test_preempt;
    int f0;
    send_byte(8'h45, 1'b1, 0);
    f0 = fall_cnt;
    send_byte(8'h82, 1'b1, 0);
    checks++;
    if ({motor_l, motor_r, busy} !== 5'b01011 || fall_cnt !== f0) begin
      failures++;
      $display("FAIL preempt_switch: got %b falls=%0d expected 01011 falls=0", {motor_l, motor_r, busy}, fall_cnt - f0);
    end
    wait_idle(300);
    checks++;
    if (fall_cnt !== f0 + 1 || fall_cyc - valid_cyc !== 201) begin
      failures++;
      $display("FAIL preempt_duration: got %0d expected 200", fall_cyc - valid_cyc - 1);
    end
  endtask

  task automatic test_glitch;
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    @(negedge clk) rx_i = 1'b0;
    repeat (5) @(negedge clk);
    rx_i = 1'b1;
    repeat (200) @(negedge clk);
    #1;
    checks++;
    if (valid_cnt !== v0 || err_cnt !== e0) begin
      failures++;
      $display("FAIL glitch_reject: valids=%0d errs=%0d expected 0/0", valid_cnt - v0, err_cnt - e0);
    end
    send_byte(8'h55, 1'b1, 0);
    checks++;
    if (valid_cnt !== v0 + 1 || cmd_byte !== 8'h55) begin
      failures++;
      $display("FAIL glitch_recover: valids=%0d byte=%h expected 1/55", valid_cnt - v0, cmd_byte);
    end
  endtask

  task automatic test_frame_err;
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_byte(8'h41, 1'b0, 40);
    checks++;
    if (err_cnt !== e0 + 1 || valid_cnt !== v0) begin
      failures++;
      $display("FAIL frame_err_pulse: errs=%0d valids=%0d expected 1/0", err_cnt - e0, valid_cnt - v0);
    end
    checks++;
    if (cmd_byte !== 8'h55) begin
      failures++;
      $display("FAIL frame_err_hold: got %h expected 55", cmd_byte);
    end
    checks++;
    if ({motor_l, motor_r, busy} !== 5'b10101) begin
      failures++;
      $display("FAIL frame_err_motion: got %b expected 10101", {motor_l, motor_r, busy});
    end
    send_byte(8'h42, 1'b1, 0);
    checks++;
    if (cmd_byte !== 8'h42 || valid_cnt !== v0 + 1 || err_cnt !== e0 + 1) begin
      failures++;
      $display("FAIL frame_err_recover: byte=%h valids=%0d errs=%0d expected 42/1/1", cmd_byte, valid_cnt - v0, err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid;
    int v0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_busy: got %b expected 1", busy);
    end
    @(negedge clk) rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({cmd_byte, cmd_valid, frame_err, motor_l, motor_r, busy} !== 15'b0) begin
      failures++;
      $display("FAIL async_reset: byte=%h motion=%b expected 00/00000", cmd_byte, {motor_l, motor_r, busy});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    v0 = valid_cnt;
    send_byte(8'h47, 1'b1, 0);
    checks++;
    if (valid_cnt !== v0 + 1 || cmd_byte !== 8'h47) begin
      failures++;
      $display("FAIL post_reset_rx: valids=%0d byte=%h expected 1/47", valid_cnt - v0, cmd_byte);
    end
    checks++;
    if ({motor_l, motor_r, busy} !== 5'b10101) begin
      failures++;
      $display("FAIL post_reset_motion: got %b expected 10101", {motor_l, motor_r, busy});
    end
    wait_idle(800);
    checks++;
    if (busy !== 1'b0 || fall_cyc - rise_cyc !== 700) begin
      failures++;
      $display("FAIL post_reset_duration: got %0d expected 700", fall_cyc - rise_cyc);
    end
  endtask

  initial begin
    test_reset;
    test_fwd;
    test_turn;
    test_stop;
    test_preempt;
    test_glitch;
    test_frame_err;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
